aes_key_expander_iter: RTL and testbench

Sequential, multi-key-size AES key schedule generator: the parametrised successor to the combinational AES-128 `key_expansion`. It accepts a 128-, 192- or 256-bit cipher key on a start handshake. It computes one 32-bit schedule word per clock into an internal word store. Round keys are served to the cipher datapath through a 128-bit read port indexed by round number.

---
 rtl/aes_pkg.sv | 73 +++++++
 rtl/aes_sub_word.sv | 13 +
 rtl/aes_key_expander_iter.sv | 130 +++++++++++++
 tb/tb_aes_key_expander_iter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, S-box table and key-size helpers.
// AES_KEYEXP_256_EN enables the 256-bit key size.
package aes_pkg;

  typedef enum logic [1:0] {
    KEY_128 = 2'b00,
    KEY_192 = 2'b01,
    KEY_256 = 2'b10,
    KEY_BAD = 2'b11
  } key_size_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EXPAND = 2'b01,
    ST_DONE   = 2'b10
  } exp_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic key_size_ok(input key_size_t ks);
`ifdef AES_KEYEXP_256_EN
    return ks != KEY_BAD;
`else
    return (ks == KEY_128) || (ks == KEY_192);
`endif
  endfunction

  function automatic logic [3:0] key_nk(input key_size_t ks);
    case (ks)
      KEY_128: return 4'd4;
      KEY_192: return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] key_nr(input key_size_t ks);
    case (ks)
      KEY_128: return 4'd10;
      KEY_192: return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  function automatic logic [5:0] key_total(input key_size_t ks);
    case (ks)
      KEY_128: return 6'd44;
      KEY_192: return 6'd52;
      default: return 6'd60;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: byte-wise S-box substitution of a 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign word_out[8*gi +: 8] = SBOX[word_in[8*gi +: 8]];
  end

endmodule

// File: rtl/aes_key_expander_iter.sv
// Iterative AES key schedule: one schedule word per clock into a flop-based store.
// AES_KEYEXP_256_EN enables 256-bit keys and the mid-block SubWord step.
module aes_key_expander_iter
  import aes_pkg::*;
#(
  parameter int MAX_WORDS = 60
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [1:0]   key_size,
  input  logic [255:0] key_in,
  input  logic [3:0]   rd_round,
  output logic [127:0] rd_key,
  output logic         busy,
  output logic         keys_valid,
  output logic [3:0]   num_rounds,
  output logic         err
);

  exp_state_t  state_reg, state_next;
  logic [5:0]  i_reg;
  logic [2:0]  j_reg;
  logic [7:0]  rcon_reg;
  logic [3:0]  nk_reg;
  logic [3:0]  nr_reg;
  logic [5:0]  total_reg;
  logic        err_reg;
  logic [31:0] words_reg [MAX_WORDS];

  key_size_t   ks_in;
  logic        load_en, reject, exp_en, last_word;
  logic [3:0]  nk_new;
  logic [2:0]  j_last;
  logic [31:0] prev_word, back_word, sub_in, sub_out, temp, w_new;
  logic [5:0]  rd_base;

  assign ks_in     = key_size_t'(key_size);
  assign nk_new    = key_nk(ks_in);
  assign load_en   = (state_reg != ST_EXPAND) && start && key_size_ok(ks_in);
  assign reject    = (state_reg != ST_EXPAND) && start && !key_size_ok(ks_in);
  assign exp_en    = (state_reg == ST_EXPAND);
  assign last_word = exp_en && (i_reg == total_reg - 6'd1);
  assign j_last    = 3'(nk_reg - 4'd1);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: if (load_en) state_next = ST_EXPAND;
      ST_EXPAND:        if (last_word) state_next = ST_DONE;
      default:          state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Single SubWord instance serves both the j==0 (rotated) and j==4 cases.
  assign prev_word = words_reg[i_reg - 6'd1];
  assign back_word = words_reg[i_reg - {2'b00, nk_reg}];
  assign sub_in    = (j_reg == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

  aes_sub_word u_sub_word (
    .word_in  (sub_in),
    .word_out (sub_out)
  );

  always_comb begin
    temp = prev_word;
    if (j_reg == 3'd0) temp = sub_out ^ {rcon_reg, 24'h0};
`ifdef AES_KEYEXP_256_EN
    else if (nk_reg == 4'd8 && j_reg == 3'd4) temp = sub_out;
`endif
  end

  assign w_new = back_word ^ temp;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      i_reg     <= '0;
      j_reg     <= '0;
      rcon_reg  <= '0;
      nk_reg    <= '0;
      nr_reg    <= '0;
      total_reg <= '0;
      err_reg   <= 1'b0;
    end else if (load_en) begin
      i_reg     <= {2'b00, nk_new};
      j_reg     <= '0;
      rcon_reg  <= 8'h01;
      nk_reg    <= nk_new;
      nr_reg    <= key_nr(ks_in);
      total_reg <= key_total(ks_in);
      err_reg   <= 1'b0;
    end else if (reject) begin
      err_reg   <= 1'b1;
    end else if (exp_en) begin
      i_reg <= i_reg + 6'd1;
      j_reg <= (j_reg == j_last) ? 3'd0 : j_reg + 3'd1;
      if (j_reg == 3'd0) rcon_reg <= xtime(rcon_reg);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < MAX_WORDS; k++) words_reg[k] <= '0;
    end else if (load_en) begin
      for (int k = 0; k < 8; k++)
        if (k < int'(nk_new)) words_reg[k] <= key_in[255-32*k -: 32];
    end else if (exp_en) begin
      words_reg[i_reg] <= w_new;
    end
  end

  assign busy       = (state_reg == ST_EXPAND);
  assign keys_valid = (state_reg == ST_DONE);
  assign num_rounds = nr_reg;
  assign err        = err_reg;

  assign rd_base = {rd_round, 2'b00};
  always_comb begin
    rd_key = '0;
    if (keys_valid && rd_round <= nr_reg)
      rd_key = {words_reg[rd_base], words_reg[rd_base + 6'd1],
                words_reg[rd_base + 6'd2], words_reg[rd_base + 6'd3]};
  end

endmodule

// File: tb/tb_aes_key_expander_iter.sv
// Self-checking bench for aes_key_expander_iter against a FIPS-197 style reference model.
module tb_aes_key_expander_iter;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   key_size = 2'b00;
  logic [255:0] key_in = '0;
  logic [3:0]   rd_round = 4'd0;
  logic [127:0] rd_key;
  logic         busy, keys_valid, err;
  logic [3:0]   num_rounds;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  sb [256];
  logic [31:0] mw [60];

  always #5 clk = ~clk;

  aes_key_expander_iter #(.MAX_WORDS(60)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .key_size   (key_size),
    .key_in     (key_in),
    .rd_round   (rd_round),
    .rd_key     (rd_key),
    .busy       (busy),
    .keys_valid (keys_valid),
    .num_rounds (num_rounds),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = (x[7]) ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box derived from the GF(2^8) inverse and the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  task automatic model_expand(input int nk, input logic [255:0] key);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) mw[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] model_round(input int nk, input int r);
    if (r > nk + 6) return 128'h0;
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  function automatic int nk_of(input logic [1:0] ks);
    return (ks == 2'b00) ? 4 : (ks == 2'b01) ? 6 : 8;
  endfunction

  task automatic read_round(input int r, output logic [127:0] v);
    rd_round = 4'(r);
    #1;
    v = rd_key;
  endtask

  // Start a run, optionally pulse start mid-run, then check timing and every round key.
  task automatic run_expand(input string tag, input logic [1:0] ks, input logic [255:0] key,
                            input int pulse_at);
    int nk = nk_of(ks);
    int cnt = 0;
    logic [127:0] v;
    model_expand(nk, key);
    @(negedge clk);
    start = 1'b1; key_size = ks; key_in = key;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_edge0"}, 128'(busy), 128'd1);
    chk({tag, "_valid_edge0"}, 128'(keys_valid), 128'd0);
    while (keys_valid !== 1'b1 && cnt < 100) begin
      if (cnt == pulse_at) begin
        start = 1'b1; key_size = 2'b11; key_in = {$urandom, $urandom, $urandom, $urandom,
                                                  $urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      start = 1'b0;
      cnt++;
    end
    chk({tag, "_cycles"}, 128'(cnt), 128'(3 * nk + 28));
    chk({tag, "_busy_done"}, 128'(busy), 128'd0);
    chk({tag, "_err"}, 128'(err), 128'd0);
    chk({tag, "_num_rounds"}, 128'(num_rounds), 128'(nk + 6));
    for (int r = 0; r < 16; r++) begin
      read_round(r, v);
      chk($sformatf("%s_round%0d", tag, r), v, model_round(nk, r));
    end
    $display("txn %s: size=%0d nk=%0d cycles=%0d", tag, ks, nk, cnt);
  endtask

  initial begin
    logic [127:0] v;
    logic [255:0] rk;
    build_sbox();

    repeat (2) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_valid", 128'(keys_valid), 128'd0);
    chk("rst_err", 128'(err), 128'd0);
    chk("rst_num_rounds", 128'(num_rounds), 128'd0);
    for (int r = 0; r < 16; r++) begin
      read_round(r, v);
      chk($sformatf("rst_round%0d", r), v, 128'h0);
    end
    n_rst = 1'b1;
    $display("txn reset: released");

    rk = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
`ifdef AES_KEYEXP_256_EN
    run_expand("fips256", 2'b10, rk, -1);
    read_round(14, v);
    chk("fips256_w59", 128'(v[31:0]), 128'h706c631e);
`else
    @(negedge clk);
    start = 1'b1; key_size = 2'b10; key_in = rk;
    @(negedge clk);
    start = 1'b0;
    chk("k256_dis_err", 128'(err), 128'd1);
    chk("k256_dis_busy", 128'(busy), 128'd0);
    chk("k256_dis_valid", 128'(keys_valid), 128'd0);
    chk("k256_dis_num_rounds", 128'(num_rounds), 128'd0);
    $display("txn k256_disabled: err=%0b", err);
`endif

    rk = {128'h6c756b65696d796f7572666174686572, 128'h0};
    run_expand("luke128", 2'b00, rk, -1);
    read_round(0, v);
    chk("luke128_round0", v, 128'h6c756b65696d796f7572666174686572);
    read_round(1, v);
    chk("luke128_w4", 128'(v[127:96]), 128'h28382bf7);

    rk = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_cafef00d_01234567_89abcdef};
    run_expand("fips128", 2'b00, rk, -1);
    read_round(10, v);
    chk("fips128_round10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_round(11, v);
    chk("fips128_round11", v, 128'h0);

    rk = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'hffffffff_ffffffff};
    run_expand("fips192", 2'b01, rk, -1);
    read_round(12, v);
    chk("fips192_w51", 128'(v[31:0]), 128'h01002202);

    // Invalid size while DONE: flag only, keys retained.
    @(negedge clk);
    start = 1'b1; key_size = 2'b11; key_in = '1;
    @(negedge clk);
    start = 1'b0;
    chk("bad_err", 128'(err), 128'd1);
    chk("bad_valid_kept", 128'(keys_valid), 128'd1);
    chk("bad_busy", 128'(busy), 128'd0);
    read_round(12, v);
    chk("bad_keys_kept", 128'(v[31:0]), 128'h01002202);
    $display("txn bad_size: err=%0b keys_valid=%0b", err, keys_valid);

    for (int n = 0; n < 6; n++) begin
      logic [1:0] ks;
`ifdef AES_KEYEXP_256_EN
      ks = 2'(n % 3);
`else
      ks = 2'(n % 2);
`endif
      rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_expand($sformatf("rand%0d", n), ks, rk, -1);
    end

    rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_expand("midpulse", 2'b00, rk, 10);

    // Reset twenty cycles into a run.
    @(negedge clk);
    start = 1'b1; key_size = 2'b00; key_in = rk ^ 256'h1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_valid", 128'(keys_valid), 128'd0);
    chk("midrst_num_rounds", 128'(num_rounds), 128'd0);
    chk("midrst_err", 128'(err), 128'd0);
    repeat (2) @(negedge clk);
    for (int r = 0; r < 11; r++) begin
      read_round(r, v);
      chk($sformatf("midrst_round%0d", r), v, 128'h0);
    end
    n_rst = 1'b1;
    $display("txn mid_reset: busy=%0b keys_valid=%0b", busy, keys_valid);

    rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_expand("post_rst", 2'b00, rk, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
